avr_pmem: RTL and testbench

AVR_PMEM -- requirements
Module: avr_pmem

---
 rtl/avr_pkg.sv | 13 +
 rtl/avr_pmem_ram.sv | 22 ++
 rtl/avr_pmem.sv | 121 ++++++++++++
 tb/tb_avr_pmem.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/avr_pkg.sv
// Shared definitions for the AVR program memory slice: FSM state encoding and instruction constants.
package avr_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    SERVE   = 2'd0,
    LOAD_LO = 2'd1,
    LOAD_HI = 2'd2
  } pmem_state_e;

endpackage

// File: rtl/avr_pmem_ram.sv
// Single-port synchronous program RAM, 2^AW x 16, registered read with read enable.
import avr_pkg::*;

module avr_pmem_ram #(
  parameter int AW = 9
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [AW-1:0]      addr,
  input  logic [INSTR_W-1:0] wdata,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/avr_pmem.sv
// AVR program memory: serves CPU fetches and accepts a little-endian byte image from a loader.
import avr_pkg::*;

module avr_pmem #(
  parameter int AW = 9
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [AW-1:0]      p_addr,
  input  logic               p_req,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               cpu_hold,
  input  logic               ld_start,
  input  logic [7:0]         ld_byte,
  input  logic               ld_valid,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic [AW:0]        ld_count,
  output logic               ld_err
);

  pmem_state_e        state_q, state_d;
  logic [AW-1:0]      waddr_q;
  logic [AW:0]        cnt_q;
  logic [7:0]         lo_q;
  logic               err_q;
  logic               valid_q;
  logic               zero_q;
  logic               accept;
  logic               we;
  logic               rd_en;
  logic [INSTR_W-1:0] wdata;
  logic [INSTR_W-1:0] rdata;
  logic [AW-1:0]      ram_addr;

  assign ld_ready = (state_q != SERVE);
  assign cpu_hold = (state_q != SERVE);
  // ld_start outranks a byte presented in the same cycle; that byte is dropped.
  assign accept   = ld_valid & ld_ready & ~ld_start;
  assign ram_addr = (state_q == SERVE) ? p_addr : waddr_q;

  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    rd_en   = 1'b0;
    wdata   = {8'h00, ld_byte};
    case (state_q)
      SERVE: begin
        if (ld_start) state_d = LOAD_LO;
        else          rd_en   = p_req;
      end
      LOAD_LO: begin
        if (ld_start) begin
          state_d = LOAD_LO;
        end else if (accept) begin
          if (ld_last) begin
            we      = 1'b1;
            state_d = SERVE;
          end else begin
            state_d = LOAD_HI;
          end
        end
      end
      LOAD_HI: begin
        if (ld_start) begin
          state_d = LOAD_LO;
        end else if (accept) begin
          we      = 1'b1;
          wdata   = {ld_byte, lo_q};
          state_d = (ld_last || (&waddr_q)) ? SERVE : LOAD_LO;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  // zero_q forces NOP on instr from load entry until the first fetch after it,
  // since the RAM output register itself is not reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= SERVE;
      waddr_q <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_q <= rd_en;
      if (ld_start) begin
        waddr_q <= '0;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end else if (we) begin
        waddr_q <= waddr_q + 1'b1;
        cnt_q   <= cnt_q + 1'b1;
        if (state_q == LOAD_LO) err_q <= 1'b1;
      end
      if (accept && state_q == LOAD_LO) lo_q <= ld_byte;
      if (state_d != SERVE) zero_q <= 1'b1;
      else if (rd_en)       zero_q <= 1'b0;
    end
  end

  avr_pmem_ram #(.AW(AW)) u_ram (
    .clk   (CLK),
    .we    (we),
    .re    (rd_en),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign instr       = zero_q ? NOP_INSTR : rdata;
  assign instr_valid = valid_q;
  assign ld_count    = cnt_q;
  assign ld_err      = err_q;

endmodule

// File: tb/tb_avr_pmem.sv
// Directed bench for avr_pmem: vector table for load/fetch, plus reset-abort and AW=2 wrap sequences.
module tb_avr_pmem;

  logic        CLK = 1'b0;
  logic        RST_N;

  logic [8:0]  p_addr;
  logic        p_req, ld_start, ld_valid, ld_last;
  logic [7:0]  ld_byte;
  logic [15:0] instr;
  logic        instr_valid, cpu_hold, ld_ready, ld_err;
  logic [9:0]  ld_count;

  logic [1:0]  p_addr2;
  logic        p_req2, ld_start2, ld_valid2, ld_last2;
  logic [7:0]  ld_byte2;
  logic [15:0] instr2;
  logic        instr_valid2, cpu_hold2, ld_ready2, ld_err2;
  logic [2:0]  ld_count2;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  avr_pmem #(.AW(9)) dut (
    .CLK(CLK), .RST_N(RST_N), .p_addr(p_addr), .p_req(p_req),
    .instr(instr), .instr_valid(instr_valid), .cpu_hold(cpu_hold),
    .ld_start(ld_start), .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_count(ld_count), .ld_err(ld_err)
  );

  avr_pmem #(.AW(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .p_addr(p_addr2), .p_req(p_req2),
    .instr(instr2), .instr_valid(instr_valid2), .cpu_hold(cpu_hold2),
    .ld_start(ld_start2), .ld_byte(ld_byte2), .ld_valid(ld_valid2), .ld_last(ld_last2),
    .ld_ready(ld_ready2), .ld_count(ld_count2), .ld_err(ld_err2)
  );

  typedef struct {
    logic        st, vld, last;
    logic [7:0]  b;
    logic        req;
    logic [8:0]  a;
    logic        e_iv;
    logic [15:0] e_instr;
    logic        e_hold, e_rdy;
    logic [9:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic vld, logic last, logic [7:0] b,
                              logic req, logic [8:0] a, logic e_iv, logic [15:0] e_instr,
                              logic e_hold, logic e_rdy, logic [9:0] e_cnt, logic e_err);
    vec_t v;
    v.st = st; v.vld = vld; v.last = last; v.b = b; v.req = req; v.a = a;
    v.e_iv = e_iv; v.e_instr = e_instr; v.e_hold = e_hold; v.e_rdy = e_rdy;
    v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle1();
    ld_start = 0; ld_valid = 0; ld_last = 0; ld_byte = 8'h00; p_req = 0; p_addr = '0;
  endtask

  task automatic check1(input string tag, input logic iv, input logic [15:0] ins,
                        input logic hold, input logic rdy, input logic [9:0] cnt, input logic err);
    chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, iv});
    chk({tag, ".instr"},       {16'd0, instr},       {16'd0, ins});
    chk({tag, ".cpu_hold"},    {31'd0, cpu_hold},    {31'd0, hold});
    chk({tag, ".ld_ready"},    {31'd0, ld_ready},    {31'd0, rdy});
    chk({tag, ".ld_count"},    {22'd0, ld_count},    {22'd0, cnt});
    chk({tag, ".ld_err"},      {31'd0, ld_err},      {31'd0, err});
  endtask

  initial begin
    //                st vld last byte  req addr | iv instr    hold rdy cnt err
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 9'd0, 0, 16'h0000, 1, 1, 10'd0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hA4, 1, 9'd0, 0, 16'h0000, 1, 1, 10'd0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hE0, 1, 9'd0, 0, 16'h0000, 1, 1, 10'd1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 9'd0, 0, 16'h0000, 1, 1, 10'd1, 0));
    tbl.push_back(mk(0, 1, 0, 8'hA1, 1, 9'd1, 0, 16'h0000, 1, 1, 10'd1, 0));
    tbl.push_back(mk(0, 1, 1, 8'h50, 1, 9'd1, 0, 16'h0000, 0, 0, 10'd2, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 9'd0, 1, 16'hE0A4, 0, 0, 10'd2, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 9'd1, 1, 16'h50A1, 0, 0, 10'd2, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 9'd0, 0, 16'h50A1, 0, 0, 10'd2, 0));
    // odd-length image
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 9'd0, 0, 16'h0000, 1, 1, 10'd0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h01, 0, 9'd0, 0, 16'h0000, 1, 1, 10'd0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h0F, 0, 9'd0, 0, 16'h0000, 1, 1, 10'd1, 0));
    tbl.push_back(mk(0, 1, 1, 8'h11, 0, 9'd0, 0, 16'h0000, 0, 0, 10'd2, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 9'd0, 1, 16'h0F01, 0, 0, 10'd2, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 9'd1, 1, 16'h0011, 0, 0, 10'd2, 1));
    // restart after three bytes
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 9'd0, 0, 16'h0000, 1, 1, 10'd0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h12, 0, 9'd0, 0, 16'h0000, 1, 1, 10'd0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h34, 0, 9'd0, 0, 16'h0000, 1, 1, 10'd1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h56, 0, 9'd0, 0, 16'h0000, 1, 1, 10'd1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 9'd0, 0, 16'h0000, 1, 1, 10'd0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hAA, 0, 9'd0, 0, 16'h0000, 1, 1, 10'd0, 0));
    tbl.push_back(mk(0, 1, 1, 8'hBB, 0, 9'd0, 0, 16'h0000, 0, 0, 10'd1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 9'd0, 1, 16'hBBAA, 0, 0, 10'd1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 9'd1, 1, 16'h0011, 0, 0, 10'd1, 0));
    // loader bytes in SERVE are ignored
    tbl.push_back(mk(0, 1, 0, 8'h99, 0, 9'd0, 0, 16'h0011, 0, 0, 10'd1, 0));

    RST_N = 1'b0;
    idle1();
    p_addr2 = '0; p_req2 = 0; ld_start2 = 0; ld_valid2 = 0; ld_last2 = 0; ld_byte2 = 8'h00;
    step();
    step();
    check1("reset", 0, 16'h0000, 0, 0, 10'd0, 0);
    chk("reset2.ld_ready", {31'd0, ld_ready2}, 32'd0);
    chk("reset2.cpu_hold", {31'd0, cpu_hold2}, 32'd0);
    chk("reset2.ld_count", {29'd0, ld_count2}, 32'd0);
    #2 RST_N = 1'b1;

    foreach (tbl[i]) begin
      ld_start = tbl[i].st; ld_valid = tbl[i].vld; ld_last = tbl[i].last;
      ld_byte = tbl[i].b; p_req = tbl[i].req; p_addr = tbl[i].a;
      step();
      check1($sformatf("vec%0d", i), tbl[i].e_iv, tbl[i].e_instr, tbl[i].e_hold,
             tbl[i].e_rdy, tbl[i].e_cnt, tbl[i].e_err);
    end

    // Reset mid-load: one word written, second word half done
    idle1(); ld_start = 1; step();
    idle1(); ld_valid = 1; ld_byte = 8'h77; step();
    ld_byte = 8'h66; step();
    chk("abort.pre_count", {22'd0, ld_count}, 32'd1);
    ld_byte = 8'h55; step();
    idle1();
    #2 RST_N = 1'b0;
    #1;
    check1("abort", 0, 16'h0000, 0, 0, 10'd0, 0);
    step();
    #2 RST_N = 1'b1;
    p_req = 1; p_addr = 9'd0;
    step();
    check1("abort.fetch", 1, 16'h6677, 0, 0, 10'd0, 0);
    idle1();

    // AW=2 wrap: 10 bytes, only 8 accepted
    ld_start2 = 1; step(); ld_start2 = 0;
    chk("wrap.start_ready", {31'd0, ld_ready2}, 32'd1);
    for (int unsigned i = 0; i < 10; i++) begin
      ld_valid2 = 1; ld_byte2 = 8'h10 + 8'(i);
      step();
      chk($sformatf("wrap.b%0d.ready", i), {31'd0, ld_ready2}, (i < 7) ? 32'd1 : 32'd0);
      chk($sformatf("wrap.b%0d.count", i), {29'd0, ld_count2}, (i < 7) ? (i + 1) / 2 : 32'd4);
    end
    ld_valid2 = 0;
    chk("wrap.err", {31'd0, ld_err2}, 32'd0);
    chk("wrap.hold", {31'd0, cpu_hold2}, 32'd0);
    for (int unsigned k = 0; k < 4; k++) begin
      p_req2 = 1; p_addr2 = 2'(k);
      step();
      chk($sformatf("wrap.rd%0d.valid", k), {31'd0, instr_valid2}, 32'd1);
      chk($sformatf("wrap.rd%0d.instr", k), {16'd0, instr2},
          {16'd0, 8'h11 + 8'(2 * k), 8'h10 + 8'(2 * k)});
    end
    p_req2 = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
